// File: rtl/sdram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sdram_arb_pkg
// Shared types and constants for the SDRAM port arbiter.
//   arb_state_t : request sequencer states (IDLE, ISSUE, WAIT)
//   arb_slot_t  : one queued access {address, write byte, write flag}
//   DS_*        : byte-lane select encodings for sd_ds
//   lane_select : picks the byte lanes for an access
// The slot address width is fixed at ARB_AW; the arbiter's AW parameter
// must match it.
// ---------------------------------------------------------------------------
package sdram_arb_pkg;

  localparam int ARB_AW = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_t;

  typedef struct packed {
    logic [ARB_AW-1:0] a;
    logic [7:0]        d;
    logic              we;
  } arb_slot_t;

  localparam logic [1:0] DS_LOW  = 2'b01;
  localparam logic [1:0] DS_HIGH = 2'b10;
  localparam logic [1:0] DS_BOTH = 2'b11;

  // Writes touch only the lane selected by address bit 0; reads fetch the
  // whole word and the lane is picked when the data comes back.
  function automatic logic [1:0] lane_select(input logic we, input logic a0);
    if (we) begin
      return a0 ? DS_HIGH : DS_LOW;
    end
    return DS_BOTH;
  endfunction

endpackage

// File: rtl/cpu_access_detect.sv
// ---------------------------------------------------------------------------
// cpu_access_detect
// Turns the level-style Oric RAM bus into one-cycle access events.
// An event fires on a rising read strobe (cs&oe), a rising write strobe
// (cs&we), or a change of address while a read is held asserted.
// Ports:
//   clk, reset          : SDRAM clock, synchronous active-high reset
//   cpu_cs/oe/we        : CPU RAM bus strobes
//   cpu_a, cpu_d        : CPU address and write data
//   evt                 : one-cycle access event (combinational)
//   evt_slot            : access captured alongside evt
// ---------------------------------------------------------------------------
module cpu_access_detect
  import sdram_arb_pkg::*;
#(
  parameter int AW = ARB_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_cs,
  input  logic          cpu_oe,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_a,
  input  logic [7:0]    cpu_d,
  output logic          evt,
  output arb_slot_t     evt_slot
);

  logic          rd_now;
  logic          wr_now;
  logic          rd_prev;
  logic          wr_prev;
  logic [AW-1:0] a_prev;

  assign rd_now = cpu_cs & cpu_oe;
  assign wr_now = cpu_cs & cpu_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_prev <= 1'b0;
      wr_prev <= 1'b0;
      a_prev  <= '0;
    end else begin
      rd_prev <= rd_now;
      wr_prev <= wr_now;
      a_prev  <= cpu_a;
    end
  end

  // A held read that walks to a new address is a fresh access
  // (the CPU can keep oe asserted across consecutive reads).
  always_comb begin
    evt         = (rd_now & ~rd_prev) | (wr_now & ~wr_prev) |
                  (rd_now & (cpu_a != a_prev));
    evt_slot.a  = cpu_a;
    evt_slot.d  = cpu_d;
    evt_slot.we = wr_now;
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_port_arbiter
// Shares one toggle-handshake SDRAM port between the Oric CPU RAM bus and
// the byte-wide download (ioctl) writer. CPU accesses have fixed priority.
// Ports:
//   clk, reset              : SDRAM clock (clk_72), synchronous active-high reset
//   cpu_cs/oe/we/a/d        : CPU RAM bus in
//   cpu_q                   : CPU read data, held until the next read completes
//   dl_wr/dl_a/dl_d         : download byte strobe, address, data
//   dl_ready                : download holding register free
//   sd_req/sd_ack           : toggle handshake (request pending while unequal)
//   sd_a/sd_ds/sd_we/sd_d   : request address, byte lanes, write flag, data
//   sd_q                    : SDRAM read word
//   err_timeout/err_overrun : sticky error flags
// Build option: define ARB_ROM_PROTECT_EN to drop CPU accesses at or above
// ROM_BASE (reads of that window return 8'h00).
// ---------------------------------------------------------------------------
module sdram_port_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int              AW          = ARB_AW,
  parameter int              ACK_TIMEOUT = 63,
  parameter logic [AW-1:0]   ROM_BASE    = 16'hC000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_cs,
  input  logic          cpu_oe,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_a,
  input  logic [7:0]    cpu_d,
  output logic [7:0]    cpu_q,
  input  logic          dl_wr,
  input  logic [AW-1:0] dl_a,
  input  logic [7:0]    dl_d,
  output logic          dl_ready,
  output logic          sd_req,
  input  logic          sd_ack,
  output logic [AW-1:0] sd_a,
  output logic [1:0]    sd_ds,
  output logic          sd_we,
  output logic [15:0]   sd_d,
  input  logic [15:0]   sd_q,
  output logic          err_timeout,
  output logic          err_overrun
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

`ifdef ARB_ROM_PROTECT_EN
  localparam logic ROM_PROTECT = 1'b1;
`else
  localparam logic ROM_PROTECT = 1'b0;
`endif

  arb_state_t    state;
  arb_state_t    state_next;

  logic          cpu_evt;
  arb_slot_t     cpu_evt_slot;
  logic          rom_hit;
  logic          cpu_take;
  logic          rom_read;

  arb_slot_t     cpu_slot;
  logic          cpu_pend;
  arb_slot_t     dl_slot;
  logic          dl_pend;
  logic          cur_is_dl;
  logic [TW-1:0] tmo_cnt;

  logic          issue_cpu;
  logic          issue_dl;
  logic          ack_done;
  logic          tmo_hit;
  arb_slot_t     issue_slot;

  cpu_access_detect #(
    .AW(AW)
  ) u_detect (
    .clk      (clk),
    .reset    (reset),
    .cpu_cs   (cpu_cs),
    .cpu_oe   (cpu_oe),
    .cpu_we   (cpu_we),
    .cpu_a    (cpu_a),
    .cpu_d    (cpu_d),
    .evt      (cpu_evt),
    .evt_slot (cpu_evt_slot)
  );

  // ROM window accesses are served outside this block, so they never reach
  // SDRAM; a ROM read still has to clear cpu_q so stale RAM data is not muxed.
  always_comb begin
    rom_hit  = ROM_PROTECT && (cpu_evt_slot.a >= ROM_BASE);
    cpu_take = cpu_evt & ~rom_hit;
    rom_read = cpu_evt & rom_hit & ~cpu_evt_slot.we;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Sequencer: the request is launched on the IDLE->ISSUE edge so the SDRAM
  // sees a new toggle two clocks after the CPU strobe. ISSUE is a one-cycle
  // settle before acknowledge/timeout watching starts in WAIT.
  always_comb begin
    state_next = state;
    issue_cpu  = 1'b0;
    issue_dl   = 1'b0;
    ack_done   = 1'b0;
    tmo_hit    = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_pend) begin
          issue_cpu  = 1'b1;
          state_next = ISSUE;
        end else if (dl_pend) begin
          issue_dl   = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (sd_ack == sd_req) begin
          ack_done   = 1'b1;
          state_next = IDLE;
        end else if (tmo_cnt == TW'(ACK_TIMEOUT)) begin
          tmo_hit    = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    issue_slot = issue_cpu ? cpu_slot : dl_slot;
  end

  // Pending slots, request registers and completion handling. Events are
  // captured independently of the sequencer, so an event landing on the
  // same edge as an ack or an issue is never lost; the issue uses the slot
  // contents from before that edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_slot    <= '0;
      cpu_pend    <= 1'b0;
      dl_slot     <= '0;
      dl_pend     <= 1'b0;
      dl_ready    <= 1'b1;
      cur_is_dl   <= 1'b0;
      tmo_cnt     <= '0;
      cpu_q       <= 8'h00;
      sd_req      <= 1'b0;
      sd_a        <= '0;
      sd_ds       <= 2'b00;
      sd_we       <= 1'b0;
      sd_d        <= 16'h0000;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (cpu_take) begin
        cpu_slot <= cpu_evt_slot;
        cpu_pend <= 1'b1;
        if (cpu_pend && !issue_cpu) begin
          err_overrun <= 1'b1;
        end
      end else if (issue_cpu) begin
        cpu_pend <= 1'b0;
      end

      if (dl_wr && dl_ready) begin
        dl_slot.a  <= dl_a;
        dl_slot.d  <= dl_d;
        dl_slot.we <= 1'b1;
        dl_pend    <= 1'b1;
        dl_ready   <= 1'b0;
      end else if (issue_dl) begin
        dl_pend <= 1'b0;
      end

      if (state == WAIT) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end else begin
        tmo_cnt <= '0;
      end

      if (issue_cpu || issue_dl) begin
        sd_a      <= issue_slot.a;
        sd_we     <= issue_slot.we;
        sd_ds     <= lane_select(issue_slot.we, issue_slot.a[0]);
        sd_d      <= {issue_slot.d, issue_slot.d};
        sd_req    <= ~sd_req;
        cur_is_dl <= issue_dl;
      end

      if (ack_done) begin
        if (!sd_we && !cur_is_dl) begin
          cpu_q <= sd_a[0] ? sd_q[15:8] : sd_q[7:0];
        end
        if (cur_is_dl) begin
          dl_ready <= 1'b1;
        end
      end

      // An abandoned download byte still frees the holding register,
      // otherwise the loader would stall forever.
      if (tmo_hit) begin
        err_timeout <= 1'b1;
        sd_req      <= sd_ack;
        if (cur_is_dl) begin
          dl_ready <= 1'b1;
        end
      end

      if (rom_read) begin
        cpu_q <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_port_arbiter
// Directed bench for sdram_port_arbiter with a simple toggle-handshake
// SDRAM responder that logs every new request.
// ---------------------------------------------------------------------------
module tb_sdram_port_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_cs;
  logic        cpu_oe;
  logic        cpu_we;
  logic [15:0] cpu_a;
  logic [7:0]  cpu_d;
  logic [7:0]  cpu_q;
  logic        dl_wr;
  logic [15:0] dl_a;
  logic [7:0]  dl_d;
  logic        dl_ready;
  logic        sd_req;
  logic        sd_ack;
  logic [15:0] sd_a;
  logic [1:0]  sd_ds;
  logic        sd_we;
  logic [15:0] sd_d;
  logic [15:0] sd_q;
  logic        err_timeout;
  logic        err_overrun;

  int          vectors;
  int          miscompares;

  logic        ack_enable;
  int          ack_delay;
  logic [15:0] ack_data;
  int          req_toggles;
  int          wait_cnt;
  logic        prev_req;
  logic [15:0] log_a   [0:7];
  logic        log_we  [0:7];
  logic [1:0]  log_ds  [0:7];
  logic [15:0] log_d   [0:7];
  logic        log_dlr [0:7];

  sdram_port_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .cpu_cs      (cpu_cs),
    .cpu_oe      (cpu_oe),
    .cpu_we      (cpu_we),
    .cpu_a       (cpu_a),
    .cpu_d       (cpu_d),
    .cpu_q       (cpu_q),
    .dl_wr       (dl_wr),
    .dl_a        (dl_a),
    .dl_d        (dl_d),
    .dl_ready    (dl_ready),
    .sd_req      (sd_req),
    .sd_ack      (sd_ack),
    .sd_a        (sd_a),
    .sd_ds       (sd_ds),
    .sd_we       (sd_we),
    .sd_d        (sd_d),
    .sd_q        (sd_q),
    .err_timeout (err_timeout),
    .err_overrun (err_overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SDRAM responder: logs each new request, then acknowledges it ack_delay
  // falling edges later with ack_data (when enabled).
  initial begin
    sd_ack      = 1'b0;
    sd_q        = 16'h0000;
    prev_req    = 1'b0;
    wait_cnt    = 0;
    req_toggles = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        sd_ack   = 1'b0;
        prev_req = 1'b0;
        wait_cnt = 0;
      end else begin
        if (sd_req !== prev_req && sd_req !== sd_ack) begin
          log_a[req_toggles % 8]   = sd_a;
          log_we[req_toggles % 8]  = sd_we;
          log_ds[req_toggles % 8]  = sd_ds;
          log_d[req_toggles % 8]   = sd_d;
          log_dlr[req_toggles % 8] = dl_ready;
          req_toggles = req_toggles + 1;
          wait_cnt    = 0;
        end else if (sd_req !== sd_ack) begin
          wait_cnt = wait_cnt + 1;
          if (ack_enable && wait_cnt >= ack_delay) begin
            sd_q   = ack_data;
            sd_ack = sd_req;
          end
        end else begin
          wait_cnt = 0;
        end
        prev_req = sd_req;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    reset  = 1'b1;
    cpu_cs = 1'b0;
    cpu_oe = 1'b0;
    cpu_we = 1'b0;
    cpu_a  = 16'h0000;
    cpu_d  = 8'h00;
    dl_wr  = 1'b0;
    dl_a   = 16'h0000;
    dl_d   = 8'h00;
    tick(3);
    reset = 1'b0;
    tick(2);
    vectors++;
    if (sd_req !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_sd_req got %b want 0", sd_req); end
    vectors++;
    if (cpu_q !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_cpu_q got %h want 00", cpu_q); end
    vectors++;
    if (dl_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_dl_ready got %b want 1", dl_ready); end
    vectors++;
    if (sd_a !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_sd_a got %h want 0000", sd_a); end
    vectors++;
    if (sd_ds !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_sd_ds got %b want 00", sd_ds); end
    vectors++;
    if (sd_we !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_sd_we got %b want 0", sd_we); end
    vectors++;
    if (sd_d !== 16'h0000) begin miscompares++; $display("[TB] FAIL reset_sd_d got %h want 0000", sd_d); end
    vectors++;
    if (err_timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err_timeout got %b want 0", err_timeout); end
    vectors++;
    if (err_overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err_overrun got %b want 0", err_overrun); end
  endtask

  task automatic test_cpu_read;
    int base;
    base      = req_toggles;
    ack_delay = 5;
    ack_data  = 16'hA55A;
    cpu_a     = 16'h0501;
    cpu_cs    = 1'b1;
    cpu_oe    = 1'b1;
    tick(1);
    cpu_cs = 1'b0;
    cpu_oe = 1'b0;
    tick(15);
    vectors++;
    if (req_toggles - base !== 1) begin miscompares++; $display("[TB] FAIL read_toggles got %0d want 1", req_toggles - base); end
    vectors++;
    if (log_a[base % 8] !== 16'h0501) begin miscompares++; $display("[TB] FAIL read_addr got %h want 0501", log_a[base % 8]); end
    vectors++;
    if (log_ds[base % 8] !== 2'b11) begin miscompares++; $display("[TB] FAIL read_ds got %b want 11", log_ds[base % 8]); end
    vectors++;
    if (log_we[base % 8] !== 1'b0) begin miscompares++; $display("[TB] FAIL read_we got %b want 0", log_we[base % 8]); end
    vectors++;
    if (cpu_q !== 8'hA5) begin miscompares++; $display("[TB] FAIL read_cpu_q got %h want a5", cpu_q); end
    vectors++;
    if (sd_req !== sd_ack) begin miscompares++; $display("[TB] FAIL read_handshake got req %b ack %b want equal", sd_req, sd_ack); end
  endtask

  task automatic test_cpu_write;
    int base;
    base   = req_toggles;
    cpu_a  = 16'h0200;
    cpu_d  = 8'h3C;
    cpu_cs = 1'b1;
    cpu_we = 1'b1;
    tick(1);
    cpu_cs = 1'b0;
    cpu_we = 1'b0;
    tick(15);
    cpu_a  = 16'h0201;
    cpu_d  = 8'h5A;
    cpu_cs = 1'b1;
    cpu_we = 1'b1;
    tick(1);
    cpu_cs = 1'b0;
    cpu_we = 1'b0;
    tick(15);
    vectors++;
    if (req_toggles - base !== 2) begin miscompares++; $display("[TB] FAIL write_toggles got %0d want 2", req_toggles - base); end
    vectors++;
    if (log_we[base % 8] !== 1'b1) begin miscompares++; $display("[TB] FAIL write_we got %b want 1", log_we[base % 8]); end
    vectors++;
    if (log_ds[base % 8] !== 2'b01) begin miscompares++; $display("[TB] FAIL write_ds_even got %b want 01", log_ds[base % 8]); end
    vectors++;
    if (log_d[base % 8] !== 16'h3C3C) begin miscompares++; $display("[TB] FAIL write_d got %h want 3c3c", log_d[base % 8]); end
    vectors++;
    if (log_a[base % 8] !== 16'h0200) begin miscompares++; $display("[TB] FAIL write_addr got %h want 0200", log_a[base % 8]); end
    vectors++;
    if (log_ds[(base + 1) % 8] !== 2'b10) begin miscompares++; $display("[TB] FAIL write_ds_odd got %b want 10", log_ds[(base + 1) % 8]); end
    vectors++;
    if (log_d[(base + 1) % 8] !== 16'h5A5A) begin miscompares++; $display("[TB] FAIL write_d_odd got %h want 5a5a", log_d[(base + 1) % 8]); end
    vectors++;
    if (cpu_q !== 8'hA5) begin miscompares++; $display("[TB] FAIL write_cpu_q_held got %h want a5", cpu_q); end
  endtask

  task automatic test_dl_and_cpu;
    int base;
    base      = req_toggles;
    ack_delay = 5;
    ack_data  = 16'h1234;
    dl_wr     = 1'b1;
    dl_a      = 16'h0300;
    dl_d      = 8'h77;
    cpu_a     = 16'h0402;
    cpu_cs    = 1'b1;
    cpu_oe    = 1'b1;
    tick(1);
    dl_wr  = 1'b0;
    cpu_cs = 1'b0;
    cpu_oe = 1'b0;
    tick(2);
    vectors++;
    if (dl_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL dl_ready_busy got %b want 0", dl_ready); end
    tick(25);
    vectors++;
    if (req_toggles - base !== 2) begin miscompares++; $display("[TB] FAIL dl_toggles got %0d want 2", req_toggles - base); end
    vectors++;
    if (log_a[base % 8] !== 16'h0402) begin miscompares++; $display("[TB] FAIL dl_first_addr got %h want 0402", log_a[base % 8]); end
    vectors++;
    if (log_a[(base + 1) % 8] !== 16'h0300) begin miscompares++; $display("[TB] FAIL dl_second_addr got %h want 0300", log_a[(base + 1) % 8]); end
    vectors++;
    if (log_we[(base + 1) % 8] !== 1'b1) begin miscompares++; $display("[TB] FAIL dl_we got %b want 1", log_we[(base + 1) % 8]); end
    vectors++;
    if (log_d[(base + 1) % 8] !== 16'h7777) begin miscompares++; $display("[TB] FAIL dl_d got %h want 7777", log_d[(base + 1) % 8]); end
    vectors++;
    if (log_dlr[(base + 1) % 8] !== 1'b0) begin miscompares++; $display("[TB] FAIL dl_ready_at_issue got %b want 0", log_dlr[(base + 1) % 8]); end
    vectors++;
    if (dl_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL dl_ready_after got %b want 1", dl_ready); end
    vectors++;
    if (cpu_q !== 8'h34) begin miscompares++; $display("[TB] FAIL dl_cpu_q got %h want 34", cpu_q); end
  endtask

  task automatic test_addr_step;
    int base;
    base      = req_toggles;
    ack_delay = 5;
    ack_data  = 16'hBEEF;
    cpu_a     = 16'h1000;
    cpu_cs    = 1'b1;
    cpu_oe    = 1'b1;
    tick(4);
    cpu_a = 16'h1001;
    tick(25);
    cpu_cs = 1'b0;
    cpu_oe = 1'b0;
    tick(2);
    vectors++;
    if (req_toggles - base !== 2) begin miscompares++; $display("[TB] FAIL step_toggles got %0d want 2", req_toggles - base); end
    vectors++;
    if (log_a[(base + 1) % 8] !== 16'h1001) begin miscompares++; $display("[TB] FAIL step_addr got %h want 1001", log_a[(base + 1) % 8]); end
    vectors++;
    if (err_overrun !== 1'b0) begin miscompares++; $display("[TB] FAIL step_overrun got %b want 0", err_overrun); end
    vectors++;
    if (cpu_q !== 8'hBE) begin miscompares++; $display("[TB] FAIL step_cpu_q got %h want be", cpu_q); end
  endtask

  task automatic test_overrun;
    int base;
    base      = req_toggles;
    ack_delay = 10;
    ack_data  = 16'h5AA5;
    cpu_a     = 16'h2000;
    cpu_cs    = 1'b1;
    cpu_oe    = 1'b1;
    tick(4);
    cpu_a = 16'h2001;
    tick(1);
    cpu_a = 16'h2002;
    tick(30);
    cpu_cs = 1'b0;
    cpu_oe = 1'b0;
    tick(2);
    vectors++;
    if (err_overrun !== 1'b1) begin miscompares++; $display("[TB] FAIL overrun_flag got %b want 1", err_overrun); end
    vectors++;
    if (req_toggles - base !== 2) begin miscompares++; $display("[TB] FAIL overrun_toggles got %0d want 2", req_toggles - base); end
    vectors++;
    if (log_a[(base + 1) % 8] !== 16'h2002) begin miscompares++; $display("[TB] FAIL overrun_addr got %h want 2002", log_a[(base + 1) % 8]); end
    vectors++;
    if (cpu_q !== 8'hA5) begin miscompares++; $display("[TB] FAIL overrun_cpu_q got %h want a5", cpu_q); end
  endtask

  task automatic test_timeout;
    int base;
    base       = req_toggles;
    ack_enable = 1'b0;
    cpu_a      = 16'h0600;
    cpu_cs     = 1'b1;
    cpu_oe     = 1'b1;
    tick(1);
    cpu_cs = 1'b0;
    cpu_oe = 1'b0;
    tick(49);
    vectors++;
    if (err_timeout !== 1'b0) begin miscompares++; $display("[TB] FAIL timeout_early got %b want 0", err_timeout); end
    tick(25);
    vectors++;
    if (err_timeout !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_flag got %b want 1", err_timeout); end
    vectors++;
    if (sd_req !== sd_ack) begin miscompares++; $display("[TB] FAIL timeout_resync got req %b ack %b want equal", sd_req, sd_ack); end
    vectors++;
    if (req_toggles - base !== 1) begin miscompares++; $display("[TB] FAIL timeout_toggles got %0d want 1", req_toggles - base); end
    ack_enable = 1'b1;
    ack_delay  = 4;
    cpu_a      = 16'h0700;
    cpu_d      = 8'h11;
    cpu_cs     = 1'b1;
    cpu_we     = 1'b1;
    tick(1);
    cpu_cs = 1'b0;
    cpu_we = 1'b0;
    tick(15);
    vectors++;
    if (req_toggles - base !== 2) begin miscompares++; $display("[TB] FAIL after_timeout_toggles got %0d want 2", req_toggles - base); end
    vectors++;
    if (log_a[(base + 1) % 8] !== 16'h0700) begin miscompares++; $display("[TB] FAIL after_timeout_addr got %h want 0700", log_a[(base + 1) % 8]); end
    vectors++;
    if (sd_req !== sd_ack) begin miscompares++; $display("[TB] FAIL after_timeout_done got req %b ack %b want equal", sd_req, sd_ack); end
    vectors++;
    if (err_timeout !== 1'b1) begin miscompares++; $display("[TB] FAIL timeout_sticky got %b want 1", err_timeout); end
  endtask

`ifdef ARB_ROM_PROTECT_EN
  task automatic test_rom_protect;
    int base;
    base      = req_toggles;
    ack_delay = 4;
    ack_data  = 16'hFFFF;
    cpu_a     = 16'hC123;
    cpu_cs    = 1'b1;
    cpu_oe    = 1'b1;
    tick(1);
    cpu_cs = 1'b0;
    cpu_oe = 1'b0;
    tick(15);
    vectors++;
    if (req_toggles - base !== 0) begin miscompares++; $display("[TB] FAIL rom_read_toggles got %0d want 0", req_toggles - base); end
    vectors++;
    if (cpu_q !== 8'h00) begin miscompares++; $display("[TB] FAIL rom_cpu_q got %h want 00", cpu_q); end
    dl_wr = 1'b1;
    dl_a  = 16'hC123;
    dl_d  = 8'h99;
    tick(1);
    dl_wr = 1'b0;
    tick(15);
    vectors++;
    if (req_toggles - base !== 1) begin miscompares++; $display("[TB] FAIL rom_dl_toggles got %0d want 1", req_toggles - base); end
    vectors++;
    if (log_a[base % 8] !== 16'hC123) begin miscompares++; $display("[TB] FAIL rom_dl_addr got %h want c123", log_a[base % 8]); end
    vectors++;
    if (log_ds[base % 8] !== 2'b10) begin miscompares++; $display("[TB] FAIL rom_dl_ds got %b want 10", log_ds[base % 8]); end
  endtask
`endif

  initial begin
    vectors     = 0;
    miscompares = 0;
    ack_enable  = 1'b1;
    ack_delay   = 5;
    ack_data    = 16'h0000;
    test_reset();
    test_cpu_read();
    test_cpu_write();
    test_dl_and_cpu();
    test_addr_step();
    test_overrun();
    test_timeout();
`ifdef ARB_ROM_PROTECT_EN
    test_rom_protect();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
